operand_stack_b2b: RTL
======================

Name: operand_stack_b2b

Overview:
- Parametrised operand storage for the calculator datapath.
- Generalises the single 5-bit load/output-enable operand register into a DEPTH-entry LIFO stack of WIDTH-bit operands.
- Adds push/pop/swap/load operations, occupancy and error status, and a selectable output transform: pass, one's complement or two's complement.
- Sits between the keypad/BCD entry logic and the ALU. The ALU reads top and next-to-top.

Parameters:
WIDTH, 5, operand width in bits (>=2)
DEPTH, 4, number of stack entries (>=2)
CNT_W, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

Ports:
clock  input  1  datapath clock; all state updates on falling edge
reset  input  1  asynchronous, active-low reset (0 = reset)
push  input  1  push input_data onto stack
pop  input  1  discard top entry
swap  input  1  exchange top and next-to-top
load  input  1  overwrite top entry with input_data
input_data  input  WIDTH  operand to push/load
output_enable  input  1  gates output_data
out_mode  input  2  00 pass, 01 one's complement, 10 two's complement, 11 force zero
clear_err  input  1  clears sticky error flags
output_data  output  WIDTH  transformed top entry (combinational)
next_data  output  WIDTH  raw next-to-top entry (combinational)
count  output  CNT_W  number of valid entries
empty  output  1  count==0
full  output  1  count==DEPTH
overflow  output  1  sticky: push attempted when full
underflow  output  1  sticky: pop/swap/load attempted with too few entries

Behaviour:
- Reset (reset==0, asynchronous assert; release sampled at next falling edge):
  - all entries 0, count 0, overflow 0, underflow 0.
  - Resulting outputs: output_data 0, next_data 0, empty 1, full 0.
  - Reset mid-operation discards all contents immediately.
- State updates on falling clock edge only. One operation per edge, fixed priority push > pop > swap > load; lower-priority strobes in the same cycle are ignored (no error from them).
- push:
  - count<DEPTH: new entry becomes top, old entries shift down by one, count+1.
  - full: no state change, overflow<=1.
- pop:
  - count>0: top removed, count-1; the vacated slot is cleared to 0.
  - empty: no change, underflow<=1.
- swap:
  - count>=2: top and next exchanged, count unchanged.
  - count<2: no change, underflow<=1.
- load:
  - count>=1: top<=input_data, count unchanged.
  - empty: no change, underflow<=1.
- Op with no strobe: hold.
- Flags:
  - overflow/underflow are sticky. clear_err clears both on the edge.
  - If clear_err and a new error occur on the same edge, the new error's flag reads 1 and the other flag clears.
- Outputs:
  - output_data = 0 when output_enable==0.
  - Otherwise, with T = top (0 if empty):
    - 00: T
    - 01: ~T
    - 10: (~T+1) truncated to WIDTH; the most negative value maps to itself, e.g. 5'b10000 -> 5'b10000, and 0 -> 0.
    - 11: 0
  - next_data is the raw entry below top, or 0 if count<2. It is not affected by output_enable or out_mode.
  - count/empty/full are registered-state derived (no combinational path from strobes).
- Latency: effect of an operation visible on outputs immediately after the falling edge that performs it. Changes to output_enable/out_mode affect output_data combinationally, with zero latency.

Test Plan:
- (WIDTH=5, DEPTH=4) Reset low, then release; push 3, 7, 12 -> count 3, output_data (oe=1, mode 00) = 12, next_data 7, empty 0, full 0.
- Push 1 and 2 on consecutive edges from count 3 -> count 4 after first push, full 1, second push ignored, overflow 1, top 1; then pop on the next edge -> count 3, top 12, overflow still 1.
- Top = 5'b00110 with out_mode 01/10/11 -> 5'b11001 / 5'b11010 / 0; top 5'b10000 with mode 10 -> 5'b10000; output_enable=0 -> 0 in all modes.
- Stack [9 top, 4]: swap -> top 4, next 9. Then push and pop asserted together with input_data 21 -> push wins, count 3, top 21.
- Empty stack: pop, swap, load each asserted -> count stays 0, underflow 1. Assert clear_err together with a pop on empty -> underflow reads 1. clear_err alone on the next edge -> underflow 0.
- Reset asserted asynchronously between edges with count 3 -> count 0, empty 1, output_data 0 without waiting for a clock edge; contents not recovered after release.

Source files
------------

// File: rtl/operand_stack_b2b.sv
// -----------------------------------------------------------------------------
// operand_stack_b2b
//   DEPTH-entry LIFO of WIDTH-bit operands for the calculator datapath.
//   The stack sits between the keypad/BCD entry logic and the ALU. The ALU
//   reads the top entry, after an output transform, and the raw
//   next-to-top entry.
//
//   State changes on the falling edge of clock. At most one operation runs
//   per edge, in the fixed priority push > pop > swap > load.
//
// Ports
//   clock          datapath clock (state updates on falling edge)
//   reset          asynchronous active-low reset
//   push/pop/swap/load  operation strobes
//   input_data     operand for push/load
//   output_enable  gates output_data to zero when low
//   out_mode       00 pass, 01 one's compl, 10 two's compl, 11 zero
//   clear_err      clears the sticky error flags
//   output_data    transformed top entry (combinational)
//   next_data      raw next-to-top entry, 0 if fewer than two entries
//   count          number of valid entries
//   empty/full     occupancy status
//   overflow       sticky: push attempted while full
//   underflow      sticky: pop/swap/load attempted with too few entries
// -----------------------------------------------------------------------------
module operand_stack_b2b #(
    parameter  int WIDTH = 5,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             swap,
    input  logic             load,
    input  logic [WIDTH-1:0] input_data,
    input  logic             output_enable,
    input  logic [1:0]       out_mode,
    input  logic             clear_err,
    output logic [WIDTH-1:0] output_data,
    output logic [WIDTH-1:0] next_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] DATA_ONE  = WIDTH'(1);

    // Entry 0 is the top of the stack. Entries at or above count are always
    // zero, so a pop leaves the vacated slot cleared.
    logic [WIDTH-1:0] stack_r     [DEPTH];
    logic [WIDTH-1:0] stack_nxt_s [DEPTH];
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             overflow_r;
    logic             overflow_nxt_s;
    logic             underflow_r;
    logic             underflow_nxt_s;
    logic [WIDTH-1:0] top_s;

    // Output transform of the top entry. The two's complement wraps, so the
    // most negative value maps to itself and zero maps to zero.
    function automatic logic [WIDTH-1:0] out_transform(
        input logic [WIDTH-1:0] value,
        input logic [1:0]       mode
    );
        logic [WIDTH-1:0] result;
        case (mode)
            2'b00:   result = value;
            2'b01:   result = ~value;
            2'b10:   result = ~value + DATA_ONE;
            2'b11:   result = DATA_ZERO;
            default: result = DATA_ZERO;
        endcase
        return result;
    endfunction

    // Next-state logic: one prioritised operation per edge, plus sticky flags.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stack_nxt_s[i] = stack_r[i];
        end
        count_nxt_s     = count_r;
        // clear_err drops both flags; a new error on the same edge re-sets its own.
        overflow_nxt_s  = clear_err ? 1'b0 : overflow_r;
        underflow_nxt_s = clear_err ? 1'b0 : underflow_r;

        if (push) begin
            if (count_r < CNT_DEPTH) begin
                for (int i = 1; i < DEPTH; i++) begin
                    stack_nxt_s[i] = stack_r[i-1];
                end
                stack_nxt_s[0] = input_data;
                count_nxt_s    = count_r + CNT_ONE;
            end else begin
                overflow_nxt_s = 1'b1;
            end
        end else if (pop) begin
            if (count_r != CNT_ZERO) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    stack_nxt_s[i] = stack_r[i+1];
                end
                stack_nxt_s[DEPTH-1] = DATA_ZERO;
                count_nxt_s          = count_r - CNT_ONE;
            end else begin
                underflow_nxt_s = 1'b1;
            end
        end else if (swap) begin
            if (count_r >= CNT_TWO) begin
                stack_nxt_s[0] = stack_r[1];
                stack_nxt_s[1] = stack_r[0];
            end else begin
                underflow_nxt_s = 1'b1;
            end
        end else if (load) begin
            if (count_r != CNT_ZERO) begin
                stack_nxt_s[0] = input_data;
            end else begin
                underflow_nxt_s = 1'b1;
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // State register: falling-edge update, asynchronous clear on reset low.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_r[i] <= DATA_ZERO;
            end
            count_r     <= CNT_ZERO;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_r[i] <= stack_nxt_s[i];
            end
            count_r     <= count_nxt_s;
            overflow_r  <= overflow_nxt_s;
            underflow_r <= underflow_nxt_s;
        end
    end

    // Output decode: data paths are combinational from state and controls.
    always_comb begin
        top_s = (count_r != CNT_ZERO) ? stack_r[0] : DATA_ZERO;
        if (output_enable) begin
            output_data = out_transform(top_s, out_mode);
        end else begin
            output_data = DATA_ZERO;
        end
        next_data = (count_r >= CNT_TWO) ? stack_r[1] : DATA_ZERO;
        count     = count_r;
        empty     = (count_r == CNT_ZERO);
        full      = (count_r == CNT_DEPTH);
        overflow  = overflow_r;
        underflow = underflow_r;
    end

endmodule
